// File: rtl/fire_ctrl.sv
// Sequencer for one convolution pass: for each output window it clears the PE
// accumulators, streams 9 kernel taps from the weight RAM, captures the sum and offers it.
module fire_ctrl #(
  parameter int ACC_W = 257
) (
  input  logic             Clk,
  input  logic             reset,
  input  logic             start,
  input  logic [7:0]       num_win,
  input  logic [7:0]       w_base,
  output logic             w_rd,
  output logic [7:0]       w_addr,
  input  logic [7:0]       w_rdata,
  output logic [7:0]       in_weight,
  output logic             ld_MAC,
  output logic             acc_clr,
  output logic [3:0]       tap_idx,
  output logic [7:0]       win_idx,
  input  logic [ACC_W-1:0] PE_added,
  output logic [ACC_W-1:0] result,
  output logic             result_valid,
  input  logic             result_ready,
  output logic             busy,
  output logic             done,
  output logic [2:0]       state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CLR  = 3'd1,
    S_MAC  = 3'd2,
    S_CAP  = 3'd3,
    S_OUT  = 3'd4
  } state_t;

  state_t           state, state_nxt;
  logic [7:0]       num_win_q, w_base_q, win_q;
  logic [3:0]       tap_q;
  logic [ACC_W-1:0] result_q;
  logic             done_q, done_nxt;
  logic             xfer, last_win;

  always_ff @(posedge Clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Handshake: result_valid is high only in OUT; a transfer happens on a clock edge
  // where result_valid && result_ready, and result is held unchanged until then.
  always_comb begin
    state_nxt = state;
    done_nxt  = 1'b0;
    xfer      = 1'b0;
    last_win  = ({1'b0, win_q} + 9'd1) >= {1'b0, num_win_q};
    case (state)
      S_IDLE: begin
        if (start) begin
          if (num_win != 8'd0) state_nxt = S_CLR;
          else                 done_nxt  = 1'b1;
        end
      end
      S_CLR: state_nxt = S_MAC;
      S_MAC: if (tap_q == 4'd8) state_nxt = S_CAP;
      S_CAP: state_nxt = S_OUT;
      S_OUT: begin
        if (result_ready) begin
          xfer = 1'b1;
          if (last_win) begin
            state_nxt = S_IDLE;
            done_nxt  = 1'b1;
          end else begin
            state_nxt = S_CLR;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (reset) begin
      num_win_q <= '0;
      w_base_q  <= '0;
      win_q     <= '0;
      tap_q     <= '0;
      result_q  <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= done_nxt;
      if (state == S_IDLE && start && num_win != 8'd0) begin
        num_win_q <= num_win;
        w_base_q  <= w_base;
        win_q     <= '0;
      end
      // tap counter only runs in MAC and is back at zero for the next window
      tap_q <= (state == S_MAC && tap_q != 4'd8) ? tap_q + 4'd1 : 4'd0;
      if (state == S_CAP) result_q <= PE_added;
      if (xfer && !last_win) win_q <= win_q + 8'd1;
    end
  end

  always_comb begin
    w_rd         = 1'b0;
    w_addr       = '0;
    in_weight    = '0;
    ld_MAC       = 1'b0;
    acc_clr      = 1'b0;
    tap_idx      = '0;
    result_valid = 1'b0;
    case (state)
      S_CLR: begin
        acc_clr = 1'b1;
        w_rd    = 1'b1;
        w_addr  = w_base_q;
      end
      S_MAC: begin
        ld_MAC    = 1'b1;
        in_weight = w_rdata;
        tap_idx   = tap_q;
        if (tap_q != 4'd8) begin
          w_rd   = 1'b1;
          w_addr = w_base_q + {4'd0, tap_q} + 8'd1;
        end
      end
      S_OUT:   result_valid = 1'b1;
      default: ;
    endcase
  end

  assign win_idx   = win_q;
  assign result    = result_q;
  assign busy      = (state != S_IDLE);
  assign done      = done_q;
  assign state_dbg = state;

endmodule
